// File: rtl/run_detect_ctrl_if.sv
// Handshake bundle for run_detect_ctrl.
//   in_valid/in_ready/in_data/span_en : word input from the parallel producer
//   out_valid/out_ready/out_hits/out_any : per-word result to the consumer
// master: producer/consumer side (testbench or front end); slave: the controller.
interface run_detect_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int HW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             span_en;
  logic             out_valid;
  logic             out_ready;
  logic [HW-1:0]    out_hits;
  logic             out_any;

  modport master (
    output in_valid, in_data, span_en, out_ready,
    input  in_ready, out_valid, out_hits, out_any
  );

  modport slave (
    input  in_valid, in_data, span_en, out_ready,
    output in_ready, out_valid, out_hits, out_any
  );
endinterface

// File: rtl/run_detect_ctrl.sv
// run_detect_ctrl: accepts parallel words, shifts them out MSB-first, flags
// runs of RUN_LEN or more consecutive ones, and reports the hit count per word.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   bus        run_detect_ctrl_if.slave (word input and result handshakes)
//   ser_valid  serial bit is live this cycle
//   ser_bit    current serial bit (MSB of the shift register)
//   ser_hit    current bit completes or extends a qualifying run
//   clr_total  synchronous clear of total_hits (wins over a same-cycle hit)
//   total_hits saturating total of hit bits since reset/clear
module run_detect_ctrl #(
  parameter int WIDTH   = 8,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  run_detect_ctrl_if.slave bus,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_hit,
  input  logic             clr_total,
  output logic [CNT_W-1:0] total_hits
);

  localparam int HW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0]    RUN_MAX = 4'(RUN_LEN);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       run;
  logic [3:0]       run_next;
  logic [HW-1:0]    word_hits;
  logic             last_bit;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  assign last_bit = (bit_cnt == LAST);

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_next = SHIFT;
      SHIFT:   if (last_bit)      state_next = REPORT;
      REPORT:  if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Run tracker saturates at RUN_LEN, so every further 1 keeps matching.
  always_comb begin
    run_next = '0;
    if (shreg[WIDTH-1]) run_next = (run == RUN_MAX) ? RUN_MAX : run + 4'd1;
  end

  // Output decode
  always_comb begin
    bus.in_ready  = (state == IDLE);
    ser_valid     = (state == SHIFT);
    ser_bit       = ser_valid & shreg[WIDTH-1];
    ser_hit       = ser_valid & (run_next == RUN_MAX);
    bus.out_valid = (state == REPORT);
    bus.out_hits  = word_hits;
    bus.out_any   = |word_hits;
  end

  // Word datapath; run survives REPORT/IDLE unless a word is accepted without span_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      run       <= '0;
      word_hits <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shreg     <= bus.in_data;
            bit_cnt   <= '0;
            word_hits <= '0;
            if (!bus.span_en) run <= '0;
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CW'(1);
          run     <= run_next;
          if (ser_hit) word_hits <= word_hits + HW'(1);
        end
        default: ;
      endcase
    end
  end

  // Saturating total
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          total_hits <= '0;
    else if (clr_total)                  total_hits <= '0;
    else if (ser_hit && !(&total_hits))  total_hits <= total_hits + CNT_W'(1);
  end

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Self-checking bench for run_detect_ctrl: a table of directed words with
// hand-computed hit masks, plus backpressure, clear, saturation and
// mid-word reset sequences. A CNT_W=3 instance sees the same stimulus.
module tb_run_detect_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr_total = 1'b0;
  logic iv = 1'b0;
  logic [7:0] idata = '0;
  logic span = 1'b0;
  logic ordy = 1'b1;

  logic ser_valid, ser_bit, ser_hit;
  logic ser_valid3, ser_bit3, ser_hit3;
  logic [7:0] total_hits;
  logic [2:0] total3;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int exp_total = 0;
  int exp_total3 = 0;

  run_detect_ctrl_if #(.WIDTH(8)) bus ();
  run_detect_ctrl_if #(.WIDTH(8)) bus3 ();

  assign bus.in_valid   = iv;
  assign bus.in_data    = idata;
  assign bus.span_en    = span;
  assign bus.out_ready  = ordy;
  assign bus3.in_valid  = iv;
  assign bus3.in_data   = idata;
  assign bus3.span_en   = span;
  assign bus3.out_ready = ordy;

  run_detect_ctrl #(.WIDTH(8), .RUN_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .ser_valid(ser_valid), .ser_bit(ser_bit), .ser_hit(ser_hit),
    .clr_total(clr_total), .total_hits(total_hits)
  );

  run_detect_ctrl #(.WIDTH(8), .RUN_LEN(4), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave),
    .ser_valid(ser_valid3), .ser_bit(ser_bit3), .ser_hit(ser_hit3),
    .clr_total(clr_total), .total_hits(total3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       span;
    logic [7:0] mask;  // expected ser_hit per bit, MSB = first bit
    int         hits;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},   bus.in_ready, 1);
    check({tag, "_ser_valid"},  ser_valid, 0);
    check({tag, "_ser_bit"},    ser_bit, 0);
    check({tag, "_ser_hit"},    ser_hit, 0);
    check({tag, "_out_valid"},  bus.out_valid, 0);
    check({tag, "_out_hits"},   bus.out_hits, 0);
    check({tag, "_out_any"},    bus.out_any, 0);
    check({tag, "_total"},      total_hits, 0);
    check({tag, "_total3"},     total3, 0);
  endtask

  // Drives one word from a negedge, checks every serial bit, the result
  // cycle, and both totals. bp holds out_ready low for 5 REPORT cycles;
  // clr_at (1..8) pulses clr_total in the cycle of that bit.
  task automatic run_word(input logic [7:0] d, input logic sp, input logic [7:0] mask,
                          input int hits, input bit bp, input int clr_at);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    iv = 1'b1; idata = d; span = sp;
    if (bp) ordy = 1'b0;
    @(negedge clk);
    iv = 1'b0; idata = ~d; span = ~sp;  // must be ignored after accept
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ser_valid[%0d]", i), ser_valid, 1);
      check($sformatf("ser_bit[%0d]", i), ser_bit, d[7-i]);
      check($sformatf("ser_hit[%0d]", i), ser_hit, mask[7-i]);
      if (i == 0) check("in_ready_shift", bus.in_ready, 0);
      clr_total = (i + 1 == clr_at);
      if (i + 1 == clr_at) begin
        exp_total = 0;
        exp_total3 = 0;
      end else if (mask[7-i]) begin
        if (exp_total < 255) exp_total++;
        if (exp_total3 < 7) exp_total3++;
      end
      @(negedge clk);
    end
    clr_total = 1'b0;
    check("out_valid", bus.out_valid, 1);
    check("out_hits", bus.out_hits, hits);
    check("out_any", bus.out_any, hits != 0);
    check("ser_valid_report", ser_valid, 0);
    check("total_hits", total_hits, exp_total);
    check("total3", total3, exp_total3);
    if (bp) begin
      iv = 1'b1; idata = 8'hFF; span = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_out_hits", bus.out_hits, hits);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_ser_valid", ser_valid, 0);
      end
      iv = 1'b0;
      ordy = 1'b1;
      @(negedge clk);
      check("bp_release_out_valid", bus.out_valid, 0);
      check("bp_release_in_ready", bus.in_ready, 1);
    end
  endtask

  initial begin
    int seen;
    vecs[0]  = '{8'hF0, 1'b0, 8'b0001_0000, 1};
    vecs[1]  = '{8'hFF, 1'b0, 8'b0001_1111, 5};
    vecs[2]  = '{8'hF0, 1'b0, 8'b0001_0000, 1};  // run from FF cleared
    vecs[3]  = '{8'h03, 1'b1, 8'b0000_0000, 0};  // ends with run=2
    vecs[4]  = '{8'hC0, 1'b1, 8'b0100_0000, 1};  // carries run, hit on bit 2
    vecs[5]  = '{8'h03, 1'b0, 8'b0000_0000, 0};
    vecs[6]  = '{8'hC0, 1'b0, 8'b0000_0000, 0};  // run cleared, no hit
    vecs[7]  = '{8'hFF, 1'b1, 8'b0001_1111, 5};  // ends with run saturated
    vecs[8]  = '{8'h0F, 1'b1, 8'b0000_0001, 1};  // leading zeros break run
    vecs[9]  = '{8'hF0, 1'b1, 8'b1111_0000, 4};  // saturated run carried in
    vecs[10] = '{8'hAA, 1'b0, 8'b0000_0000, 0};
    vecs[11] = '{8'h00, 1'b1, 8'b0000_0000, 0};

    #1;
    check_reset_vals("reset_async");
    repeat (2) @(negedge clk);
    check_reset_vals("reset_held");
    reset = 1'b1;

    foreach (vecs[k]) run_word(vecs[k].data, vecs[k].span, vecs[k].mask, vecs[k].hits, 1'b0, 0);

    // Backpressure on a hit word.
    run_word(8'hF0, 1'b0, 8'b0001_0000, 1, 1'b1, 0);

    // Clear from idle.
    @(negedge clk);
    clr_total = 1'b1;
    @(negedge clk);
    clr_total = 1'b0;
    exp_total = 0;
    exp_total3 = 0;
    check("clr_idle_total", total_hits, 0);
    check("clr_idle_total3", total3, 0);

    // Saturation of the 3-bit counter.
    for (int w = 0; w < 3; w++) run_word(8'hFF, 1'b0, 8'b0001_1111, 5, 1'b0, 0);
    check("sat_total8", total_hits, 15);
    check("sat_total3", total3, 7);

    // Clear in the same cycle as the final hit of a word.
    run_word(8'hFF, 1'b0, 8'b0001_1111, 5, 1'b0, 8);
    check("clr_hit_total", total_hits, 0);

    // Reset during bit 3 of an all-ones word.
    run_word(8'hFF, 1'b0, 8'b0001_1111, 5, 1'b0, 0);
    @(negedge clk);
    iv = 1'b1; idata = 8'hFF; span = 1'b0;
    @(negedge clk);
    iv = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_ser_valid", ser_valid, 1);
    reset = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    exp_total = 0;
    exp_total3 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.out_valid || ser_valid) seen++;
    end
    check("no_result_after_reset", seen, 0);
    // span_en=1 shows the run was cleared by reset: only bit 4 hits.
    run_word(8'hF0, 1'b1, 8'b0001_0000, 1, 1'b0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
